// File: rtl/boot_loader.sv
// Purpose: receives a framed byte stream (A5, LEN_HI, LEN_LO, data..., CSUM) and writes the data into program memory; holds the core in reset until a good frame lands.
// Latency: one cycle from byte acceptance to the progWe strobe; back-to-back bytes give back-to-back writes; cpuNotReset rises one cycle after the checksum byte.
// Backpressure: rxReady is low only in RUN; within a frame every offered byte is taken, and idle gaps are bounded by TIMEOUT.
module boot_loader #(
    parameter int          ADDR_W  = 12,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int          TIMEOUT = 50000
) (
    input  logic              clk,
    input  logic              notReset,
    input  logic [7:0]        rxData,
    input  logic              rxValid,
    output logic              rxReady,
    input  logic              bootReq,
    output logic              progWe,
    output logic [ADDR_W-1:0] progAddr,
    output logic [7:0]        progData,
    output logic              cpuNotReset,
    output logic              busy,
    output logic              error
);

    // Timer only needs to reach TIMEOUT-1 before the expiry decision is made.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Largest LEN field that still fits the program address space.
    localparam logic [31:0] MAX_LEN = 32'((64'd1 << ADDR_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;        // next write address within the image
    logic [ADDR_W:0]   cnt_q, cnt_d;        // data bytes still expected (N fits only with the extra bit)
    logic [7:0]        sum_q, sum_d;
    logic [3:0]        len_hi_q, len_hi_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              cpu_q, cpu_d;
    logic              err_q, err_d;

    logic              accept;
    logic              busy_w;
    logic [31:0]       len_w;

    assign rxReady = (state_q != S_RUN);
    assign accept  = rxValid && rxReady;
    assign busy_w  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                     (state_q == S_DATA)   || (state_q == S_CSUM);
    assign len_w   = {20'd0, len_hi_q, rxData};

    assign busy        = busy_w;
    assign progWe      = we_q;
    assign progAddr    = addr_q;
    assign progData    = data_q;
    assign cpuNotReset = cpu_q;
    assign error       = err_q;

    // Register all loader state; synchronous reset overrides everything, including a frame in flight.
    always_ff @(posedge clk) begin
        if (!notReset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            len_hi_q <= '0;
            timer_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            cpu_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            len_hi_q <= len_hi_d;
            timer_q  <= timer_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cpu_q    <= cpu_d;
            err_q    <= err_d;
        end
    end

    // Frame parser: next state, write strobe, checksum, length counter and idle timer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        len_hi_d = len_hi_q;
        timer_d  = timer_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        cpu_d    = cpu_q;
        err_d    = err_q;

        if (bootReq) begin
            // Abort wins over any byte in this cycle; error flag is kept for diagnosis.
            state_d = S_IDLE;
            cpu_d   = 1'b0;
            timer_d = '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR: begin
                    timer_d = '0;
                    if (accept && (rxData == HEADER)) begin
                        state_d = S_LEN_HI;
                        err_d   = 1'b0;
                        sum_d   = '0;
                        idx_d   = '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        if (rxData[7:4] != 4'd0) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            len_hi_d = rxData[3:0];
                            state_d  = S_LEN_LO;
                        end
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if (len_w > MAX_LEN) begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end else begin
                            cnt_d   = (ADDR_W+1)'(len_w) + (ADDR_W+1)'(1);
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        we_d   = 1'b1;
                        addr_d = idx_q;
                        data_d = rxData;
                        idx_d  = idx_q + ADDR_W'(1);
                        sum_d  = sum_q + rxData;
                        cnt_d  = cnt_q - (ADDR_W+1)'(1);
                        if (cnt_q == (ADDR_W+1)'(1)) begin
                            state_d = S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        if (rxData == sum_q) begin
                            state_d = S_RUN;
                            cpu_d   = 1'b1;
                        end else begin
                            state_d = S_ERR;
                            err_d   = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    timer_d = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            // Inter-byte idle timer: cleared by every accepted byte, expiry aborts the frame.
            if (busy_w) begin
                if (accept) begin
                    timer_d = '0;
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Purpose: directed bench for boot_loader with hand-computed frames and expected write traffic.
// Latency: drives inputs 1 time unit after the rising edge and samples there, so each registered output is checked one cycle after its cause.
// Backpressure: the only stall the loader applies is in RUN; the bench offers bytes back-to-back unless a stall is being exercised.
module tb_boot_loader;

    logic        clk;
    logic        notReset;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic        bootReq;
    logic        progWe;
    logic [11:0] progAddr;
    logic [7:0]  progData;
    logic        cpuNotReset;
    logic        busy;
    logic        error;

    int n_chk;
    int n_err;

    int         we_cnt;
    logic [11:0] last_addr;
    logic [7:0]  mem [0:4095];

    boot_loader #(
        .ADDR_W  (12),
        .HEADER  (8'hA5),
        .TIMEOUT (20)
    ) dut (
        .clk         (clk),
        .notReset    (notReset),
        .rxData      (rxData),
        .rxValid     (rxValid),
        .rxReady     (rxReady),
        .bootReq     (bootReq),
        .progWe      (progWe),
        .progAddr    (progAddr),
        .progData    (progData),
        .cpuNotReset (cpuNotReset),
        .busy        (busy),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write strobe into a shadow image of program memory.
    always @(negedge clk) begin
        if (progWe) begin
            mem[progAddr] <= progData;
            last_addr     <= progAddr;
            we_cnt        <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one byte for one cycle; returns 1 unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_boot();
        bootReq = 1'b1;
        @(posedge clk);
        #1;
        bootReq = 1'b0;
    endtask

    // The reference frame: data 3E 11 C0, checksum 0F.
    task automatic good_frame();
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h3E); send(8'h11); send(8'hC0); send(8'h0F);
    endtask

    initial begin
        int base;
        int bad;
        logic [7:0] s;
        logic [7:0] b;

        n_chk = 0; n_err = 0; we_cnt = 0; last_addr = '0;
        notReset = 1'b0; bootReq = 1'b0; rxValid = 1'b0; rxData = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;

        // Reset state
        idle(3);
        chk("rst_rdy",  rxReady, 1);
        chk("rst_we",   progWe, 0);
        chk("rst_addr", progAddr, 0);
        chk("rst_data", progData, 0);
        chk("rst_cpu",  cpuNotReset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err",  error, 0);
        notReset = 1'b1;
        idle(1);

        // 1. Valid frame, write timing 1 cycle after each byte
        send(8'h13);                       // non-header byte ignored in IDLE
        chk("t1_idle_busy", busy, 0);
        send(8'hA5);
        chk("t1_busy_hdr", busy, 1);
        send(8'h00); send(8'h02);
        chk("t1_we_pre", progWe, 0);
        send(8'h3E);
        chk("t1_w0", {progWe, progAddr, progData}, {1'b1, 12'h000, 8'h3E});
        send(8'h11);
        chk("t1_w1", {progWe, progAddr, progData}, {1'b1, 12'h001, 8'h11});
        send(8'hC0);
        chk("t1_w2", {progWe, progAddr, progData}, {1'b1, 12'h002, 8'hC0});
        chk("t1_cpu_pre", cpuNotReset, 0);
        send(8'h0F);
        chk("t1_we_hold", {progWe, progAddr, progData}, {1'b0, 12'h002, 8'hC0});
        chk("t1_cpu",  cpuNotReset, 1);
        chk("t1_err",  error, 0);
        chk("t1_rdy",  rxReady, 0);
        chk("t1_busy", busy, 0);
        chk("t1_cnt",  we_cnt, 3);
        chk("t1_mem",  {mem[0], mem[1], mem[2]}, {8'h3E, 8'h11, 8'hC0});
        send(8'hA5);                       // ignored while running
        idle(2);
        chk("t1_run_ign", {cpuNotReset, busy, 32'(we_cnt)}, {1'b1, 1'b0, 32'd3});

        // 6a. bootReq from RUN
        pulse_boot();
        chk("t6_boot_cpu", cpuNotReset, 0);
        chk("t6_boot_rdy", rxReady, 1);
        chk("t6_boot_st",  {busy, error}, 2'b00);

        // 2. Bad checksum, then resend
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h3E); send(8'h11); send(8'hC0); send(8'h10);
        chk("t2_err",  error, 1);
        chk("t2_cpu",  cpuNotReset, 0);
        chk("t2_busy", {busy, rxReady}, 2'b01);
        send(8'hA5);
        chk("t2_err_clr", error, 0);
        send(8'h00); send(8'h02);
        send(8'h3E); send(8'h11); send(8'hC0); send(8'h0F);
        chk("t2_run", {cpuNotReset, error}, 2'b10);

        // 3. Bad LEN_HI
        pulse_boot();
        base = we_cnt;
        send(8'hA5); send(8'h10);
        chk("t3_err",  {error, busy, cpuNotReset}, 3'b100);
        idle(3);
        chk("t3_no_we", we_cnt - base, 0);

        // 4. Maximum image, 4096 bytes back-to-back
        base = we_cnt;
        s = 8'h00;
        send(8'hA5); send(8'h0F); send(8'hFF);
        for (int i = 0; i < 4096; i++) begin
            b = 8'((i * 7 + 3) & 255);
            s = s + b;
            send(b);
            if (i == 0) chk("t4_w0", {progWe, progAddr, progData}, {1'b1, 12'h000, 8'h03});
        end
        chk("t4_busy", busy, 1);
        chk("t4_lastw", {progWe, progAddr}, {1'b1, 12'hFFF});
        send(s);
        chk("t4_cnt",  we_cnt - base, 4096);
        chk("t4_last", last_addr, 12'hFFF);
        bad = 0;
        for (int i = 0; i < 4096; i++) begin
            if (mem[i] !== 8'((i * 7 + 3) & 255)) bad++;
        end
        chk("t4_mem", bad, 0);
        chk("t4_run", {cpuNotReset, error}, 2'b10);

        // 5. Timeout: 20-cycle stall fails, 19-cycle stall survives
        pulse_boot();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h3E);
        idle(19);
        chk("t5_st19", {busy, error}, 2'b10);
        idle(1);
        chk("t5_to", {busy, error, cpuNotReset}, 3'b010);
        send(8'hA5); send(8'h00); send(8'h02); send(8'h3E);
        idle(19);
        send(8'h11); send(8'hC0); send(8'h0F);
        chk("t5_ok", {cpuNotReset, error, busy}, 3'b100);

        // 6b. Reset mid-DATA
        pulse_boot();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h3E); send(8'h11);
        chk("t6_pre", {progWe, progAddr, progData}, {1'b1, 12'h001, 8'h11});
        notReset = 1'b0;
        rxData   = 8'hC0;
        rxValid  = 1'b1;
        @(posedge clk);
        #1;
        rxValid = 1'b0;
        chk("t6_rst", {rxReady, progWe, progAddr, progData, cpuNotReset, busy, error},
                      {1'b1, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0});
        notReset = 1'b1;
        idle(1);
        good_frame();
        chk("t6_after", {cpuNotReset, error}, 2'b10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
